// File: rtl/mp_pkg.sv
// Shared types and widths for the motion-pipeline frame feeder.
// Tag bundle travels alongside each outstanding memory read.
package mp_pkg;

  localparam int WIDTH_BITS  = 11;
  localparam int HEIGHT_BITS = 10;
  localparam int ADDR_BITS   = WIDTH_BITS + HEIGHT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feed_state_e;

  typedef struct packed {
    logic valid;
    logic last;
    logic bg;
  } feed_tag_t;

endpackage

// File: rtl/mp_feed_tag_pipe.sv
// Delay line that keeps read tags aligned with memory read latency.
// Output tag lines up with the cycle the read data is valid.
module mp_feed_tag_pipe
  import mp_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  feed_tag_t tag_i,
  output feed_tag_t tag_o
);

  feed_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mp_frame_feeder.sv
// Raster-scan read issuer and latency-aligned pixel feeder
// for the motion pipeline.
module mp_frame_feeder
  import mp_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   bg_mode,
  input  logic [WIDTH_BITS-1:0]  width,
  input  logic [HEIGHT_BITS-1:0] height,
  input  logic                   stall,
  output logic                   rd_en,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic [31:0]            frm_rd_data,
  input  logic [31:0]            bg_rd_data,
  output logic                   enable,
  output logic [31:0]            rbg_pixel,
  output logic [31:0]            memory_pixel,
  output logic                   wr_background,
  output logic                   last_in_frame,
  output logic                   busy,
  output logic                   frame_done
);

  feed_state_e state_q, state_d;

  logic [WIDTH_BITS-1:0]  w_q, w_d, x_q, x_d;
  logic [HEIGHT_BITS-1:0] h_q, h_d, y_q, y_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   bg_q, bg_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic       issue;
  logic       x_end, last_pix;
  feed_tag_t  tag_in, tag_out;

  logic        en_q, last_q, wbg_q;
  logic [31:0] rbg_q, mem_q;

  assign x_end    = (x_q == w_q - WIDTH_BITS'(1));
  assign last_pix = x_end && (y_q == h_q - HEIGHT_BITS'(1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    bg_d    = bg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    tag_in  = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          w_d    = width;
          h_d    = height;
          bg_d   = bg_mode;
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
          busy_d = 1'b1;
          // Empty frame: finish immediately without leaving IDLE
          if (width == '0 || height == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          issue  = 1'b1;
          tag_in = '{valid: 1'b1, last: last_pix, bg: bg_q};
          addr_d = addr_q + ADDR_BITS'(1);
          if (x_end) begin
            x_d = '0;
            y_d = y_q + HEIGHT_BITS'(1);
          end else begin
            x_d = x_q + WIDTH_BITS'(1);
          end
          if (last_pix) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      bg_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mp_feed_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Pixel registers hold their value between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
      wbg_q  <= 1'b0;
      rbg_q  <= '0;
      mem_q  <= '0;
    end else begin
      en_q   <= tag_out.valid;
      last_q <= tag_out.valid & tag_out.last;
      wbg_q  <= tag_out.valid & tag_out.bg;
      if (tag_out.valid) begin
        rbg_q <= frm_rd_data;
        mem_q <= bg_rd_data;
      end
    end
  end

  assign rd_en         = issue;
  assign rd_addr       = issue ? addr_q : '0;
  assign enable        = en_q;
  assign rbg_pixel     = rbg_q;
  assign memory_pixel  = mem_q;
  assign wr_background = wbg_q;
  assign last_in_frame = last_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule
